// File: rtl/fft_frame_sequencer_pkg.sv
// Shared types and helpers for the FFT frame sequencer: FSM encoding and beat/bin index helpers.
package fft_frame_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StDrain = 2'd2
  } seq_state_e;

  // Beat and sample counters carry one extra bit so that a full frame count N is representable.
  function automatic int unsigned beat_cnt_w(int unsigned frame_log2);
    return frame_log2 + 1;
  endfunction

  // Bins eligible for peak tracking: 1 .. N/2-1 (DC and the mirrored upper half excluded).
  function automatic logic is_peak_bin(int unsigned bin, int unsigned frame_log2);
    return (bin != 0) && (bin < (32'd1 << (frame_log2 - 1)));
  endfunction

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Streaming links between the sequencer and the FFT core: sample stream out, magnitude stream back.
interface fft_frame_sequencer_if #(
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned FRAME_LOG2 = 10,
  parameter int unsigned MAG_W      = 16
);
  logic [2*SAMPLE_W-1:0] fft_tdata;
  logic                  fft_tvalid;
  logic                  fft_tready;
  logic                  fft_tlast;
  logic [MAG_W-1:0]      mag_tdata;
  logic [FRAME_LOG2-1:0] mag_tuser;
  logic                  mag_tvalid;
  logic                  mag_tlast;

  modport master (
    output fft_tdata, fft_tvalid, fft_tlast,
    input  fft_tready,
    input  mag_tdata, mag_tuser, mag_tvalid, mag_tlast
  );

  modport slave (
    input  fft_tdata, fft_tvalid, fft_tlast,
    output fft_tready,
    output mag_tdata, mag_tuser, mag_tvalid, mag_tlast
  );
endinterface

// File: rtl/fft_frame_sequencer_ram.sv
// Circular sample store: one write port, one registered read port with one cycle of latency.
module frame_sample_ram #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  localparam int unsigned Depth = 1 << ADDR_W;

  logic [WIDTH-1:0] mem_q [Depth];

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/fft_frame_sequencer.sv
// Buffers a sample stream, cuts overlapping frames into the FFT, and tracks the spectrum peak.
module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 8,
  parameter int unsigned FRAME_LOG2 = 10,
  parameter int unsigned HOP_LOG2   = 9,
  parameter int unsigned MAG_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_sample,
  input  logic                       consumer_ready,
  fft_frame_sequencer_if.master      stream,
  output logic                       bram_we,
  output logic [FRAME_LOG2-1:0]      bram_addr,
  output logic [MAG_W-1:0]           bram_din,
  output logic                       frame_done,
  output logic [FRAME_LOG2-1:0]      peak_bin,
  output logic [MAG_W-1:0]           peak_mag,
  output logic                       overrun,
  output logic                       busy
);
  localparam int unsigned     CntW     = beat_cnt_w(FRAME_LOG2);
  localparam logic [CntW-1:0] FrameLen = CntW'(1) << FRAME_LOG2;
  localparam logic [CntW-1:0] HopLen   = CntW'(1) << HOP_LOG2;

  seq_state_e            state_q, state_d;
  logic [FRAME_LOG2-1:0] wr_ptr_q;
  logic [FRAME_LOG2-1:0] start_q, start_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [CntW-1:0]       issued_q, issued_d;
  logic [CntW-1:0]       sent_q, sent_d;
  logic                  primed_q, primed_d;
  logic                  pending_q, pending_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [FRAME_LOG2-1:0] run_bin_q, run_bin_d, peak_bin_q, peak_bin_d;
  logic [MAG_W-1:0]      run_mag_q, run_mag_d, peak_mag_q, peak_mag_d;

  logic                  trigger;
  logic                  start_frame;
  logic                  rd_en;
  logic                  accept;
  logic                  mag_take;
  logic [FRAME_LOG2-1:0] rd_addr;
  logic [FRAME_LOG2-1:0] wr_off;
  logic [SAMPLE_W-1:0]   rd_data;

  frame_sample_ram #(
    .WIDTH  (SAMPLE_W),
    .ADDR_W (FRAME_LOG2)
  ) u_ram (
    .clock (clock),
    .we    (in_valid),
    .waddr (wr_ptr_q),
    .wdata (in_sample),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rd_addr  = start_q + issued_q[FRAME_LOG2-1:0];
  assign wr_off   = wr_ptr_q - start_q;
  assign accept   = tvalid_q && stream.fft_tready;
  assign mag_take = (state_q == StDrain) && stream.mag_tvalid;

  // Frame trigger: first after N samples, then every H samples.
  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
    trigger  = 1'b0;
    if (in_valid) begin
      if ((cnt_q + 1'b1) == (primed_q ? HopLen : FrameLen)) begin
        trigger  = 1'b1;
        cnt_d    = '0;
        primed_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    issued_d    = issued_q;
    sent_d      = sent_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    pending_d   = pending_q;
    done_d      = 1'b0;
    overrun_d   = 1'b0;
    run_bin_d   = run_bin_q;
    run_mag_d   = run_mag_q;
    peak_bin_d  = peak_bin_q;
    peak_mag_d  = peak_mag_q;
    start_frame = 1'b0;
    rd_en       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q && consumer_ready) begin
          start_frame = 1'b1;
          state_d     = StSend;
          start_d     = wr_ptr_q;
          issued_d    = '0;
          sent_d      = '0;
          run_bin_d   = '0;
          run_mag_d   = '0;
        end
      end
      StSend: begin
        // Only read ahead when the output slot is empty or being emptied this cycle.
        rd_en = (issued_q != FrameLen) && (!tvalid_q || accept);
        if (accept) begin
          sent_d   = sent_q + 1'b1;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
        if (rd_en) begin
          tvalid_d = 1'b1;
          tlast_d  = (issued_q == (FrameLen - 1'b1));
          issued_d = issued_q + 1'b1;
        end
        if (accept && tlast_q) state_d = StDrain;
        if (in_valid && ({1'b0, wr_off} >= sent_q)) overrun_d = 1'b1;
      end
      StDrain: begin
        if (mag_take) begin
          if (is_peak_bin(32'(stream.mag_tuser), FRAME_LOG2) &&
              ((stream.mag_tdata > run_mag_q) ||
               ((stream.mag_tdata == run_mag_q) && (stream.mag_tuser < run_bin_q)))) begin
            run_bin_d = stream.mag_tuser;
            run_mag_d = stream.mag_tdata;
          end
          if (stream.mag_tlast) begin
            done_d     = 1'b1;
            peak_bin_d = run_bin_d;
            peak_mag_d = run_mag_d;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_frame) pending_d = 1'b0;
    if (trigger) begin
      pending_d = 1'b1;
      if (pending_q && !start_frame) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      start_q    <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      primed_q   <= 1'b0;
      pending_q  <= 1'b0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      run_bin_q  <= '0;
      run_mag_q  <= '0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
    end else begin
      state_q    <= state_d;
      if (in_valid) wr_ptr_q <= wr_ptr_q + 1'b1;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      primed_q   <= primed_d;
      pending_q  <= pending_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      run_bin_q  <= run_bin_d;
      run_mag_q  <= run_mag_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
    end
  end

  assign stream.fft_tdata  = {{SAMPLE_W{1'b0}}, rd_data};
  assign stream.fft_tvalid = tvalid_q;
  assign stream.fft_tlast  = tlast_q;

  assign bram_we    = mag_take;
  assign bram_addr  = stream.mag_tuser;
  assign bram_din   = stream.mag_tdata;
  assign frame_done = done_q;
  assign peak_bin   = peak_bin_q;
  assign peak_mag   = peak_mag_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != StIdle);
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with N=16, H=8, 8-bit samples.
module tb_fft_frame_sequencer;
  localparam int unsigned SW = 8;
  localparam int unsigned FL = 4;
  localparam int unsigned HL = 3;
  localparam int unsigned MW = 16;
  localparam int unsigned N  = 16;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic [SW-1:0] in_sample;
  logic          consumer_ready;
  logic          bram_we;
  logic [FL-1:0] bram_addr;
  logic [MW-1:0] bram_din;
  logic          frame_done;
  logic [FL-1:0] peak_bin;
  logic [MW-1:0] peak_mag;
  logic          overrun;
  logic          busy;

  int checks = 0;
  int errors = 0;

  logic [15:0]   beat_data [N];
  logic          beat_last [N];
  int            nbeats;
  logic [MW-1:0] mag_vals [N];

  fft_frame_sequencer_if #(.SAMPLE_W(SW), .FRAME_LOG2(FL), .MAG_W(MW)) bus ();

  fft_frame_sequencer #(
    .SAMPLE_W   (SW),
    .FRAME_LOG2 (FL),
    .HOP_LOG2   (HL),
    .MAG_W      (MW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_sample      (in_sample),
    .consumer_ready (consumer_ready),
    .stream         (bus),
    .bram_we        (bram_we),
    .bram_addr      (bram_addr),
    .bram_din       (bram_din),
    .frame_done     (frame_done),
    .peak_bin       (peak_bin),
    .peak_mag       (peak_mag),
    .overrun        (overrun),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [SW-1:0] v);
    in_valid  = 1'b1;
    in_sample = v;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    in_valid       = 1'b0;
    bus.mag_tvalid = 1'b0;
    bus.mag_tlast  = 1'b0;
    bus.fft_tready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Collects one frame; with toggle, tready alternates 1,0 and stalled beats must hold.
  task automatic collect(input bit toggle);
    logic        stalled;
    logic [15:0] held_d;
    logic        held_l;
    int          cyc;
    for (int k = 0; k < N; k++) begin
      beat_data[k] = 'x;
      beat_last[k] = 1'bx;
    end
    nbeats  = 0;
    stalled = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    cyc     = 0;
    bus.fft_tready = 1'b1;
    while (nbeats < N && cyc < 300) begin
      if (toggle) bus.fft_tready = ((cyc % 2) == 0);
      if (stalled) begin
        check("stall_valid", 32'(bus.fft_tvalid), 32'd1);
        check("stall_data", 32'(bus.fft_tdata), 32'(held_d));
        check("stall_last", 32'(bus.fft_tlast), 32'(held_l));
      end
      if (bus.fft_tvalid && bus.fft_tready) begin
        beat_data[nbeats] = bus.fft_tdata;
        beat_last[nbeats] = bus.fft_tlast;
        nbeats++;
      end
      stalled = bus.fft_tvalid && !bus.fft_tready;
      held_d  = bus.fft_tdata;
      held_l  = bus.fft_tlast;
      tick();
      cyc++;
    end
    bus.fft_tready = 1'b1;
    check("beat_count", 32'(nbeats), 32'(N));
    check("tvalid_drop", 32'(bus.fft_tvalid), 32'd0);
    check("busy_drain", 32'(busy), 32'd1);
  endtask

  task automatic verify(input int first);
    for (int k = 0; k < N; k++) begin
      check("beat_data", 32'(beat_data[k]), 32'(first + k));
      check("beat_last", 32'(beat_last[k]), (k == N - 1) ? 32'd1 : 32'd0);
    end
  endtask

  // Pattern A: peak at bin 3 (tie with bin 5); pattern B: peak at bin 2 (tie with bin 6).
  task automatic set_pattern(input bit pat_b);
    for (int i = 0; i < N; i++) mag_vals[i] = MW'(i);
    if (!pat_b) begin
      mag_vals[0] = 16'hFFFF; mag_vals[3] = 16'h0300;
      mag_vals[5] = 16'h0300; mag_vals[12] = 16'hFFFF;
    end else begin
      mag_vals[0] = 16'h7000; mag_vals[1] = 16'h01FF; mag_vals[2] = 16'h0200;
      mag_vals[6] = 16'h0200; mag_vals[7] = 16'h01FF; mag_vals[8] = 16'h8000;
    end
  endtask

  task automatic drain(input logic [FL-1:0] prev_bin, input logic [MW-1:0] prev_mag,
                       input logic [FL-1:0] exp_bin, input logic [MW-1:0] exp_mag);
    for (int i = 0; i < N; i++) begin
      bus.mag_tvalid = 1'b1;
      bus.mag_tuser  = FL'(i);
      bus.mag_tdata  = mag_vals[i];
      bus.mag_tlast  = (i == N - 1);
      #1;
      check("bram_we", 32'(bram_we), 32'd1);
      check("bram_addr", 32'(bram_addr), 32'(i));
      check("bram_din", 32'(bram_din), 32'(mag_vals[i]));
      check("done_early", 32'(frame_done), 32'd0);
      if (i == N / 2) begin
        check("peak_hold_bin", 32'(peak_bin), 32'(prev_bin));
        check("peak_hold_mag", 32'(peak_mag), 32'(prev_mag));
      end
      tick();
    end
    bus.mag_tvalid = 1'b0;
    bus.mag_tlast  = 1'b0;
    check("frame_done", 32'(frame_done), 32'd1);
    check("peak_bin", 32'(peak_bin), 32'(exp_bin));
    check("peak_mag", 32'(peak_mag), 32'(exp_mag));
    check("busy_idle", 32'(busy), 32'd0);
    tick();
    check("done_pulse", 32'(frame_done), 32'd0);
    check("peak_keep", 32'(peak_mag), 32'(exp_mag));
  endtask

  initial begin
    int  ov_count;
    bit  hit;
    reset          = 1'b0;
    in_valid       = 1'b0;
    in_sample      = '0;
    consumer_ready = 1'b1;
    bus.fft_tready = 1'b1;
    bus.mag_tvalid = 1'b0;
    bus.mag_tlast  = 1'b0;
    bus.mag_tuser  = '0;
    bus.mag_tdata  = '0;
    #2;
    check("rst_tvalid", 32'(bus.fft_tvalid), 32'd0);
    check("rst_tlast", 32'(bus.fft_tlast), 32'd0);
    check("rst_bram_we", 32'(bram_we), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_peak_bin", 32'(peak_bin), 32'd0);
    check("rst_peak_mag", 32'(peak_mag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    do_reset();

    // mag stream outside DRAIN must not write
    bus.mag_tvalid = 1'b1;
    bus.mag_tuser  = 4'd5;
    #1;
    check("idle_mag_ignored", 32'(bram_we), 32'd0);
    bus.mag_tvalid = 1'b0;
    tick();

    // Frame 1: samples 1..16, tready high
    for (int s = 1; s <= 16; s++) push(SW'(s));
    collect(1'b0);
    verify(1);
    set_pattern(1'b1);
    drain(4'd0, 16'h0000, 4'd2, 16'h0200);

    // Frame 2 after 8 more samples: 9..24, peak at bin 3
    for (int s = 17; s <= 24; s++) push(SW'(s));
    collect(1'b0);
    verify(9);
    set_pattern(1'b0);
    drain(4'd2, 16'h0200, 4'd3, 16'h0300);

    // Back-pressured frame: tready toggles, beats must be identical
    do_reset();
    for (int s = 1; s <= 16; s++) push(SW'(s));
    collect(1'b1);
    verify(1);
    set_pattern(1'b1);
    drain(4'd0, 16'h0000, 4'd2, 16'h0200);

    // Consumer blocked across two triggers: one overrun, one frame
    do_reset();
    consumer_ready = 1'b0;
    ov_count = 0;
    for (int s = 1; s <= 24; s++) begin
      push(SW'(s));
      if (overrun) ov_count++;
      if (s == 24) check("overrun_s24", 32'(overrun), 32'd1);
    end
    check("overrun_count", 32'(ov_count), 32'd1);
    check("blocked_busy", 32'(busy), 32'd0);
    consumer_ready = 1'b1;
    collect(1'b0);
    verify(9);
    set_pattern(1'b0);
    drain(4'd0, 16'h0000, 4'd3, 16'h0300);
    tick();
    tick();
    check("no_queued_frame", 32'(busy), 32'd0);

    // Reset during beat 6 of SEND
    do_reset();
    for (int s = 1; s <= 16; s++) push(SW'(s));
    nbeats = 0;
    hit    = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (bus.fft_tvalid) begin
        if (nbeats == 5) begin
          hit = 1'b1;
          check("beat6_data", 32'(bus.fft_tdata), 32'd6);
          reset = 1'b0;
          #1;
          check("rst_mid_tvalid", 32'(bus.fft_tvalid), 32'd0);
          check("rst_mid_busy", 32'(busy), 32'd0);
        end else begin
          nbeats++;
        end
      end
      if (!hit) tick();
    end
    check("beat6_reached", 32'(hit), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    for (int s = 31; s <= 45; s++) push(SW'(s));
    tick();
    tick();
    tick();
    check("no_early_trigger", 32'(busy), 32'd0);
    bus.fft_tready = 1'b0;
    push(SW'(46));
    tick();
    check("fresh_trigger", 32'(busy), 32'd1);
    // Writing the oldest, unsent slot during SEND flags an overrun
    push(SW'(47));
    check("send_overrun", 32'(overrun), 32'd1);
    check("send_first_beat", 32'(bus.fft_tdata), 32'd31);
    tick();
    check("overrun_pulse", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL take parameters: SAMPLE_W, default 8, signed sample width; FRAME_LOG2, default 10, log2 frame length N; HOP_LOG2, default 9, log2 hop H (HOP_LOG2 <= FRAME_LOG2); MAG_W, default 16, magnitude width.
REQ-002 clock  in  1  sole clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 in_valid  in  1  one-cycle strobe for a filtered sample; in_sample  in  SAMPLE_W  signed sample.
REQ-005 consumer_ready  in  1  downstream permits a new frame to start.
REQ-006 fft_tdata  out  2*SAMPLE_W  {imag=0, real=in_sample}; fft_tvalid  out  1; fft_tready  in  1; fft_tlast  out  1.
REQ-007 mag_tdata  in  MAG_W; mag_tuser  in  FRAME_LOG2  bin index; mag_tvalid  in  1; mag_tlast  in  1.
REQ-008 bram_we  out  1; bram_addr  out  FRAME_LOG2; bram_din  out  MAG_W  spectrum write port.
REQ-009 frame_done  out  1  pulse; peak_bin  out  FRAME_LOG2; peak_mag  out  MAG_W; overrun  out  1  pulse; busy  out  1.

Function
REQ-010 SHALL hold an N-entry circular sample buffer; each in_valid writes in_sample at wr_ptr, then wr_ptr increments modulo N; writes never stall in any state.
REQ-011 SHALL count samples since last frame trigger; first trigger after N samples post-reset, thereafter every H samples; a trigger sets frame_pending.
REQ-012 A trigger while frame_pending is already set SHALL pulse overrun one cycle and leave frame_pending set (frame skipped, not queued).
REQ-013 FSM states IDLE, SEND, DRAIN; busy = (state != IDLE).
REQ-014 IDLE -> SEND when frame_pending && consumer_ready; same edge latches start = wr_ptr (oldest sample) and clears frame_pending; a simultaneous trigger re-sets frame_pending.
REQ-015 SEND streams N samples from start upward modulo N; beat k valid only after its buffer read; fft_tdata/fft_tlast SHALL hold stable while fft_tvalid && !fft_tready.
REQ-016 fft_tlast SHALL be high only on beat N-1; after that beat is accepted, fft_tvalid drops next cycle and state -> DRAIN.
REQ-017 An in_valid during SEND writing a slot not yet sent SHALL pulse overrun; the sample is still written.
REQ-018 DRAIN: each mag_tvalid cycle drives bram_we=1, bram_addr=mag_tuser, bram_din=mag_tdata combinationally (zero latency); mag has no backpressure.
REQ-019 Peak tracker over bins 1..N/2-1 (DC and upper half excluded): strictly greater replaces; ties keep lower bin; running max reset to 0/bin 0 on SEND entry.
REQ-020 On mag_tlast accepted: next cycle frame_done=1 for one cycle, peak_bin/peak_mag update and hold until next frame_done, state -> IDLE.
REQ-021 mag_tvalid outside DRAIN SHALL be ignored (bram_we stays 0).
REQ-022 All counters/pointers unsigned, wrap modulo their widths; no arithmetic saturation.

Reset
REQ-023 Reset asserted SHALL immediately force state IDLE, wr_ptr 0, sample count 0, frame_pending 0, fft_tvalid/fft_tlast/bram_we/frame_done/overrun 0, peak_bin/peak_mag 0, busy 0.
REQ-024 Reset mid-SEND or mid-DRAIN SHALL abandon the frame; buffer contents need not be cleared; first trigger after release requires N fresh samples.

Structure
REQ-025 Shared package SHALL hold FSM state encoding and beat-index helper constants; parameters stay module-local.
REQ-026 One sub-module natural: frame_sample_ram (N x SAMPLE_W, 1 write port, 1 registered read port, 1-cycle latency).

Verification (bench with FRAME_LOG2=4, HOP_LOG2=3, SAMPLE_W=8)
REQ-027 Feed samples 1..16, consumer_ready=1, fft_tready=1 -> 16 beats real=1..16, fft_tlast on beat 16, busy high.
REQ-028 Same, fft_tready toggled 1,0 each cycle -> identical beat sequence, tdata stable during every stall.
REQ-029 Feed samples 1..24 -> second frame real=9..24; mag stream bins 0..15 with bin 5=0x0300, bin 3=0x0300, bin 0=0xFFFF, bin 12=0xFFFF -> peak_bin=3, peak_mag=0x0300, frame_done one pulse.
REQ-030 consumer_ready=0 while 16 then 8 more samples arrive -> one overrun pulse on sample 24, single frame streams once consumer_ready=1.
REQ-031 Reset low during beat 6 of SEND -> fft_tvalid=0 same cycle; after release, no trigger until 16 new samples.
